// File: rtl/qsm_readout_seq.sv
// ---------------------------------------------------------------------------
// qsm_readout_seq
//
// Readout sequencer for one QSPI master (QSM) channel. Converts the register
// bank's control pulses (reset, trig) and fields (last_reg_adr, max_dim_no,
// read_delay) into frame commands for the serial engine, stores every DIM
// word returned by the engine into the channel readout SRAM (register-major,
// device-minor, packed), and maintains the status fields read back through
// the register map.
//
// Ports
//   clk_i, rst_i          system clock, synchronous active-high reset
//   ctrl_reset_i          pulse: drive the DIM line to its Reset state
//   ctrl_trig_i           pulse: start a readout of registers 0..last_reg_adr_i
//   last_reg_adr_i        index of the last DIM register to read
//   max_dim_no_i          devices accepted per frame
//   read_delay_i          inter-frame gap in microseconds
//   tick_us_i             1 us strobe
//   eng_rst_start_o       pulse: engine issues a line reset
//   eng_rd_start_o        pulse: engine reads register eng_reg_o
//   eng_reg_o             register index of the current frame
//   eng_word_valid_i/eng_word_i  device word stream from the engine
//   eng_ack_i             pulse: engine command finished
//   eng_fb_err_i          feedback error, qualified by eng_ack_i
//   mem_we_o/mem_addr_o/mem_data_o  readout SRAM write port
//   busy_o, done_o, err_many_o, err_fb_o, dim_count_o  status
// ---------------------------------------------------------------------------
module qsm_readout_seq #(
  parameter int MEM_AW  = 7,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ctrl_reset_i,
  input  logic              ctrl_trig_i,
  input  logic [3:0]        last_reg_adr_i,
  input  logic [3:0]        max_dim_no_i,
  input  logic [9:0]        read_delay_i,
  input  logic              tick_us_i,
  output logic              eng_rst_start_o,
  output logic              eng_rd_start_o,
  output logic [3:0]        eng_reg_o,
  input  logic              eng_word_valid_i,
  input  logic [15:0]       eng_word_i,
  input  logic              eng_ack_i,
  input  logic              eng_fb_err_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [15:0]       mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_many_o,
  output logic              err_fb_o,
  output logic [3:0]        dim_count_o
);

  localparam int                TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [MEM_AW-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    RST_WAIT,
    RD_START,
    RD_WAIT,
    DELAY,
    FIN
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          reg_idx, reg_idx_nxt;
  logic [3:0]          dev_cnt, dev_cnt_nxt;
  logic [MEM_AW-1:0]   wr_addr, wr_addr_nxt;
  logic                wr_full, wr_full_nxt;
  logic [TW-1:0]       tmo_cnt, tmo_nxt;
  logic [9:0]          dly_cnt, dly_nxt;
  logic                busy, busy_nxt;
  logic                done, done_nxt;
  logic                err_many, err_many_nxt;
  logic                err_fb, err_fb_nxt;
  logic [3:0]          dim_count, dim_count_nxt;
  logic                rst_start, rst_start_nxt;
  logic                rd_start, rd_start_nxt;
  logic [3:0]          eng_reg, eng_reg_nxt;

  logic                vld_p0;
  logic [MEM_AW-1:0]   addr_p0;
  logic [15:0]         data_p0;
  logic                vld_p1;
  logic [MEM_AW-1:0]   addr_p1;
  logic [15:0]         data_p1;

  always_comb begin
    state_nxt     = state;
    reg_idx_nxt   = reg_idx;
    dev_cnt_nxt   = dev_cnt;
    wr_addr_nxt   = wr_addr;
    wr_full_nxt   = wr_full;
    tmo_nxt       = tmo_cnt;
    dly_nxt       = dly_cnt;
    done_nxt      = done;
    err_many_nxt  = err_many;
    err_fb_nxt    = err_fb;
    dim_count_nxt = dim_count;
    eng_reg_nxt   = eng_reg;
    vld_p0        = 1'b0;
    addr_p0       = addr_p1;
    data_p0       = data_p1;

    case (state)
      IDLE: begin
        // Line reset has priority over a readout request in the same cycle.
        if (ctrl_reset_i) begin
          state_nxt = RST_WAIT;
          done_nxt  = 1'b0;
          tmo_nxt   = '0;
        end else if (ctrl_trig_i) begin
          state_nxt     = RD_START;
          done_nxt      = 1'b0;
          err_many_nxt  = 1'b0;
          err_fb_nxt    = 1'b0;
          dim_count_nxt = 4'd0;
          reg_idx_nxt   = 4'd0;
          wr_addr_nxt   = '0;
          wr_full_nxt   = 1'b0;
        end
      end

      RST_WAIT: begin
        if (eng_ack_i) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          err_fb_nxt = 1'b1;
          state_nxt  = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end

      RD_START: begin
        dev_cnt_nxt = 4'd0;
        tmo_nxt     = '0;
        state_nxt   = RD_WAIT;
      end

      RD_WAIT: begin
        if (eng_word_valid_i) begin
          if (dev_cnt < max_dim_no_i) begin
            dev_cnt_nxt = dev_cnt + 4'd1;
            // Once the top address has been written the SRAM is full; later
            // words still count as devices but are silently discarded.
            if (!wr_full) begin
              vld_p0  = 1'b1;
              addr_p0 = wr_addr;
              data_p0 = eng_word_i;
              if (wr_addr == ADDR_LAST) begin
                wr_full_nxt = 1'b1;
              end else begin
                wr_addr_nxt = wr_addr + MEM_AW'(1);
              end
            end
          end else begin
            err_many_nxt = 1'b1;
          end
        end

        if (eng_ack_i) begin
          // dev_cnt_nxt already includes a word arriving with the ack.
          if (reg_idx == 4'd0) begin
            dim_count_nxt = dev_cnt_nxt;
          end
          if (eng_fb_err_i) begin
            err_fb_nxt = 1'b1;
            state_nxt  = FIN;
          end else if (reg_idx == last_reg_adr_i) begin
            state_nxt = FIN;
          end else begin
            reg_idx_nxt = reg_idx + 4'd1;
            dly_nxt     = read_delay_i;
            state_nxt   = DELAY;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_fb_nxt = 1'b1;
          state_nxt  = FIN;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end

      DELAY: begin
        // The counter is loaded on the ack edge, so a tick coinciding with
        // the ack is never seen here.
        if (dly_cnt == 10'd0) begin
          state_nxt = RD_START;
        end else if (tick_us_i) begin
          dly_nxt = dly_cnt - 10'd1;
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Command strobes and status are registered from the next state so each
    // output lines up with the state it describes.
    rst_start_nxt = (state == IDLE) && (state_nxt == RST_WAIT);
    rd_start_nxt  = (state_nxt == RD_START);
    if (rd_start_nxt) begin
      eng_reg_nxt = reg_idx_nxt;
    end
    if (state_nxt == FIN) begin
      done_nxt = 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      reg_idx   <= 4'd0;
      dev_cnt   <= 4'd0;
      wr_addr   <= '0;
      wr_full   <= 1'b0;
      tmo_cnt   <= '0;
      dly_cnt   <= 10'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_many  <= 1'b0;
      err_fb    <= 1'b0;
      dim_count <= 4'd0;
      rst_start <= 1'b0;
      rd_start  <= 1'b0;
      eng_reg   <= 4'd0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= 16'd0;
    end else begin
      state     <= state_nxt;
      reg_idx   <= reg_idx_nxt;
      dev_cnt   <= dev_cnt_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_full   <= wr_full_nxt;
      tmo_cnt   <= tmo_nxt;
      dly_cnt   <= dly_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err_many  <= err_many_nxt;
      err_fb    <= err_fb_nxt;
      dim_count <= dim_count_nxt;
      rst_start <= rst_start_nxt;
      rd_start  <= rd_start_nxt;
      eng_reg   <= eng_reg_nxt;
      // Stage p0 -> p1: registered SRAM write port
      vld_p1    <= vld_p0;
      addr_p1   <= addr_p0;
      data_p1   <= data_p0;
    end
  end

  assign eng_rst_start_o = rst_start;
  assign eng_rd_start_o  = rd_start;
  assign eng_reg_o       = eng_reg;
  assign mem_we_o        = vld_p1;
  assign mem_addr_o      = addr_p1;
  assign mem_data_o      = data_p1;
  assign busy_o          = busy;
  assign done_o          = done;
  assign err_many_o      = err_many;
  assign err_fb_o        = err_fb;
  assign dim_count_o     = dim_count;

endmodule

// File: tb/tb_qsm_readout_seq.sv
`timescale 1ns/1ps
module tb_qsm_readout_seq;
  localparam int MEM_AW  = 7;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              ctrl_reset_i;
  logic              ctrl_trig_i;
  logic [3:0]        last_reg_adr_i;
  logic [3:0]        max_dim_no_i;
  logic [9:0]        read_delay_i;
  logic              tick_us_i;
  logic              eng_rst_start_o;
  logic              eng_rd_start_o;
  logic [3:0]        eng_reg_o;
  logic              eng_word_valid_i;
  logic [15:0]       eng_word_i;
  logic              eng_ack_i;
  logic              eng_fb_err_i;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [15:0]       mem_data_o;
  logic              busy_o;
  logic              done_o;
  logic              err_many_o;
  logic              err_fb_o;
  logic [3:0]        dim_count_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  qsm_readout_seq #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ctrl_reset_i     (ctrl_reset_i),
    .ctrl_trig_i      (ctrl_trig_i),
    .last_reg_adr_i   (last_reg_adr_i),
    .max_dim_no_i     (max_dim_no_i),
    .read_delay_i     (read_delay_i),
    .tick_us_i        (tick_us_i),
    .eng_rst_start_o  (eng_rst_start_o),
    .eng_rd_start_o   (eng_rd_start_o),
    .eng_reg_o        (eng_reg_o),
    .eng_word_valid_i (eng_word_valid_i),
    .eng_word_i       (eng_word_i),
    .eng_ack_i        (eng_ack_i),
    .eng_fb_err_i     (eng_fb_err_i),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_many_o       (err_many_o),
    .err_fb_o         (err_fb_o),
    .dim_count_o      (dim_count_o)
  );

  // Passive recorder: SRAM contents, write count and frame-start log.
  logic [15:0]       mem_q [0:127];
  logic [3:0]        reg_log [0:63];
  int                wr_cnt = 0;
  int                rd_cnt = 0;
  logic [MEM_AW-1:0] last_wr_addr = '0;

  always @(negedge clk) begin
    if (mem_we_o) begin
      mem_q[mem_addr_o] = mem_data_o;
      last_wr_addr      = mem_addr_o;
      wr_cnt++;
    end
    if (eng_rd_start_o) begin
      reg_log[rd_cnt[5:0]] = eng_reg_o;
      rd_cnt++;
    end
  end

  task automatic wait_rd_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (eng_rd_start_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Engine model: wait for a frame start, return nwords words base, base+1..,
  // then ack (optionally together with the last word).
  task automatic do_frame(input int nwords, input logic [15:0] base, input bit fb,
                          input bit ack_last, input bit tick_ack);
    bit found;
    wait_rd_start(found);
    checks++;
    if (!found) begin
      $display("FAIL frame_start: eng_rd_start_o got 0 want 1 within 60 cycles");
      return;
    end
    passed++;
    @(negedge clk);
    for (int i = 0; i < nwords; i++) begin
      eng_word_valid_i = 1'b1;
      eng_word_i       = base + 16'(i);
      if (ack_last && i == nwords - 1) begin
        eng_ack_i    = 1'b1;
        eng_fb_err_i = fb;
        tick_us_i    = tick_ack;
      end
      @(negedge clk);
    end
    eng_word_valid_i = 1'b0;
    if (!ack_last || nwords == 0) begin
      eng_ack_i    = 1'b1;
      eng_fb_err_i = fb;
      tick_us_i    = tick_ack;
      @(negedge clk);
    end
    eng_ack_i    = 1'b0;
    eng_fb_err_i = 1'b0;
    tick_us_i    = 1'b0;
  endtask

  task automatic start_trig(input logic [3:0] last, input logic [3:0] maxn, input logic [9:0] dly);
    @(negedge clk);
    last_reg_adr_i = last;
    max_dim_no_i   = maxn;
    read_delay_i   = dly;
    ctrl_trig_i    = 1'b1;
    @(negedge clk);
    ctrl_trig_i    = 1'b0;
  endtask

  task automatic test_reset;
    logic [37:0] outs;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    outs = {busy_o, done_o, err_many_o, err_fb_o, dim_count_o, eng_reg_o, eng_rd_start_o,
            eng_rst_start_o, mem_we_o, mem_addr_o, mem_data_o};
    checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
    else passed++;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, eng_rd_start_o} !== 3'b000)
      $display("FAIL reset_idle: busy/done/rd got %b want 000", {busy_o, done_o, eng_rd_start_o});
    else passed++;
  endtask

  task automatic test_basic;
    int wb, rb;
    logic [15:0] exp;
    wb = wr_cnt;
    rb = rd_cnt;
    start_trig(4'd1, 4'd3, 10'd0);
    checks++;
    if (busy_o !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_o);
    else passed++;
    checks++;
    if (eng_reg_o !== 4'd0) $display("FAIL basic_reg0: got %0d want 0", eng_reg_o);
    else passed++;
    do_frame(3, 16'h00A0, 1'b0, 1'b1, 1'b0);
    do_frame(3, 16'h00B0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({done_o, busy_o} !== 2'b11) $display("FAIL basic_done_rise: done/busy got %b want 11", {done_o, busy_o});
    else passed++;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b10) $display("FAIL basic_busy_drop: done/busy got %b want 10", {done_o, busy_o});
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - wb !== 6) $display("FAIL basic_wr_count: got %0d want 6", wr_cnt - wb);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      exp = (i < 3) ? 16'h00A0 + 16'(i) : 16'h00B0 + 16'(i - 3);
      checks++;
      if (mem_q[7'(i)] !== exp) $display("FAIL basic_mem[%0d]: got %h want %h", i, mem_q[7'(i)], exp);
      else passed++;
    end
    checks++;
    if (rd_cnt - rb !== 2) $display("FAIL basic_frames: got %0d want 2", rd_cnt - rb);
    else passed++;
    checks++;
    if ({reg_log[rb[5:0]], reg_log[6'(rb + 1)]} !== 8'h01)
      $display("FAIL basic_reg_seq: got %h want 01", {reg_log[rb[5:0]], reg_log[6'(rb + 1)]});
    else passed++;
    checks++;
    if (dim_count_o !== 4'd3) $display("FAIL basic_dim_count: got %0d want 3", dim_count_o);
    else passed++;
    checks++;
    if ({err_many_o, err_fb_o} !== 2'b00) $display("FAIL basic_errs: got %b want 00", {err_many_o, err_fb_o});
    else passed++;
  endtask

  task automatic test_many;
    int wb, rb;
    logic [15:0] exp;
    wb = wr_cnt;
    rb = rd_cnt;
    start_trig(4'd1, 4'd2, 10'd0);
    do_frame(4, 16'h00C0, 1'b0, 1'b0, 1'b0);
    do_frame(4, 16'h00D0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1) $display("FAIL many_done: got %b want 1", done_o);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - wb !== 4) $display("FAIL many_wr_count: got %0d want 4", wr_cnt - wb);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      exp = (i < 2) ? 16'h00C0 + 16'(i) : 16'h00D0 + 16'(i - 2);
      checks++;
      if (mem_q[7'(i)] !== exp) $display("FAIL many_mem[%0d]: got %h want %h", i, mem_q[7'(i)], exp);
      else passed++;
    end
    checks++;
    if ({err_many_o, err_fb_o} !== 2'b10) $display("FAIL many_errs: got %b want 10", {err_many_o, err_fb_o});
    else passed++;
    checks++;
    if (dim_count_o !== 4'd2) $display("FAIL many_dim_count: got %0d want 2", dim_count_o);
    else passed++;
    checks++;
    if (rd_cnt - rb !== 2) $display("FAIL many_frames: got %0d want 2", rd_cnt - rb);
    else passed++;
  endtask

  task automatic test_fb_err;
    int rb;
    rb = rd_cnt;
    start_trig(4'd3, 4'd3, 10'd0);
    do_frame(3, 16'h0E00, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({done_o, err_fb_o} !== 2'b11) $display("FAIL fb_flags: done/err_fb got %b want 11", {done_o, err_fb_o});
    else passed++;
    repeat (20) @(negedge clk);
    checks++;
    if (rd_cnt - rb !== 1) $display("FAIL fb_abort: frames got %0d want 1", rd_cnt - rb);
    else passed++;
    checks++;
    if ({busy_o, err_many_o} !== 2'b00) $display("FAIL fb_idle: busy/err_many got %b want 00", {busy_o, err_many_o});
    else passed++;
    checks++;
    if (dim_count_o !== 4'd3) $display("FAIL fb_dim_count: got %0d want 3", dim_count_o);
    else passed++;
  endtask

  task automatic test_delay;
    int wb, rb, nt;
    bit found;
    wb = wr_cnt;
    rb = rd_cnt;
    nt = 0;
    found = 1'b0;
    start_trig(4'd1, 4'd1, 10'd5);
    do_frame(1, 16'h0F00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 80; c++) begin
      if (eng_rd_start_o) begin
        found = 1'b1;
        break;
      end
      ctrl_trig_i = (c == 0);
      tick_us_i   = (c % 3 == 2);
      if (tick_us_i) nt++;
      @(negedge clk);
    end
    ctrl_trig_i = 1'b0;
    tick_us_i   = 1'b0;
    checks++;
    if (!found) $display("FAIL delay_restart: eng_rd_start_o got 0 want 1 within 80 cycles");
    else passed++;
    checks++;
    if (nt !== 5) $display("FAIL delay_ticks: got %0d want 5", nt);
    else passed++;
    checks++;
    if (eng_reg_o !== 4'd1) $display("FAIL delay_reg1: got %0d want 1", eng_reg_o);
    else passed++;
    do_frame(1, 16'h0F10, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1) $display("FAIL delay_done: got %b want 1", done_o);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_cnt - rb, wr_cnt - wb} !== {32'd2, 32'd2})
      $display("FAIL delay_trig_ignored: frames %0d writes %0d want 2 2", rd_cnt - rb, wr_cnt - wb);
    else passed++;
    checks++;
    if (mem_q[1] !== 16'h0F10) $display("FAIL delay_mem1: got %h want 0f10", mem_q[1]);
    else passed++;
  endtask

  task automatic test_reset_cmd;
    int rb, cyc;
    rb = rd_cnt;
    @(negedge clk);
    ctrl_reset_i = 1'b1;
    ctrl_trig_i  = 1'b1;
    @(negedge clk);
    ctrl_reset_i = 1'b0;
    ctrl_trig_i  = 1'b0;
    checks++;
    if ({eng_rst_start_o, eng_rd_start_o, busy_o} !== 3'b101)
      $display("FAIL rstcmd_start: rst/rd/busy got %b want 101", {eng_rst_start_o, eng_rd_start_o, busy_o});
    else passed++;
    checks++;
    if ({done_o, err_fb_o} !== 2'b00) $display("FAIL rstcmd_clear: done/err_fb got %b want 00", {done_o, err_fb_o});
    else passed++;
    @(negedge clk);
    checks++;
    if (eng_rst_start_o !== 1'b0) $display("FAIL rstcmd_pulse: got %b want 0", eng_rst_start_o);
    else passed++;
    cyc = 1;
    while (busy_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== TIMEOUT) $display("FAIL rstcmd_timeout: busy cleared after %0d want %0d", cyc, TIMEOUT);
    else passed++;
    checks++;
    if ({busy_o, err_fb_o, done_o} !== 3'b010)
      $display("FAIL rstcmd_status: busy/err_fb/done got %b want 010", {busy_o, err_fb_o, done_o});
    else passed++;
    checks++;
    if (rd_cnt - rb !== 0) $display("FAIL rstcmd_no_read: frames got %0d want 0", rd_cnt - rb);
    else passed++;
  endtask

  task automatic test_rst_mid;
    int wb;
    bit found;
    logic [37:0] outs;
    start_trig(4'd2, 4'd1, 10'd0);
    do_frame(2, 16'h0100, 1'b0, 1'b0, 1'b0);
    wait_rd_start(found);
    checks++;
    if (!found) $display("FAIL rstmid_frame1: eng_rd_start_o got 0 want 1");
    else passed++;
    @(negedge clk);
    eng_word_valid_i = 1'b1;
    eng_word_i       = 16'h0110;
    @(negedge clk);
    eng_word_valid_i = 1'b0;
    rst_i            = 1'b1;
    checks++;
    if ({err_many_o, eng_reg_o, busy_o} !== 6'b1_0001_1)
      $display("FAIL rstmid_pre: err_many/reg/busy got %b want 100011", {err_many_o, eng_reg_o, busy_o});
    else passed++;
    @(negedge clk);
    outs = {busy_o, done_o, err_many_o, err_fb_o, dim_count_o, eng_reg_o, eng_rd_start_o,
            eng_rst_start_o, mem_we_o, mem_addr_o, mem_data_o};
    checks++;
    if (outs !== '0) $display("FAIL rstmid_outputs: got %h want 0", outs);
    else passed++;
    rst_i = 1'b0;
    wb = wr_cnt;
    start_trig(4'd0, 4'd2, 10'd0);
    do_frame(1, 16'h0120, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({done_o, dim_count_o} !== 5'b1_0001)
      $display("FAIL rstmid_restart: done/dim got %b want 10001", {done_o, dim_count_o});
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - wb !== 1 || last_wr_addr !== '0 || mem_q[0] !== 16'h0120)
      $display("FAIL rstmid_addr0: writes %0d addr %0d data %h want 1 0 0120", wr_cnt - wb, last_wr_addr, mem_q[0]);
    else passed++;
  endtask

  task automatic test_mem_full;
    int wb;
    wb = wr_cnt;
    start_trig(4'd15, 4'd15, 10'd0);
    for (int f = 0; f < 16; f++) begin
      do_frame(15, 16'h1000 + 16'(f * 15), 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (done_o !== 1'b1) $display("FAIL full_done: got %b want 1", done_o);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - wb !== 128) $display("FAIL full_wr_count: got %0d want 128", wr_cnt - wb);
    else passed++;
    checks++;
    if (last_wr_addr !== 7'd127) $display("FAIL full_last_addr: got %0d want 127", last_wr_addr);
    else passed++;
    checks++;
    if ({mem_q[0], mem_q[127]} !== {16'h1000, 16'h107F})
      $display("FAIL full_mem: got %h %h want 1000 107f", mem_q[0], mem_q[127]);
    else passed++;
    checks++;
    if ({err_many_o, err_fb_o, dim_count_o} !== 6'b00_1111)
      $display("FAIL full_status: err_many/err_fb/dim got %b want 001111", {err_many_o, err_fb_o, dim_count_o});
    else passed++;
  endtask

  initial begin
    rst_i            = 1'b1;
    ctrl_reset_i     = 1'b0;
    ctrl_trig_i      = 1'b0;
    last_reg_adr_i   = 4'd0;
    max_dim_no_i     = 4'd0;
    read_delay_i     = 10'd0;
    tick_us_i        = 1'b0;
    eng_word_valid_i = 1'b0;
    eng_word_i       = 16'd0;
    eng_ack_i        = 1'b0;
    eng_fb_err_i     = 1'b0;
    test_reset();
    test_basic();
    test_many();
    test_fb_err();
    test_delay();
    test_reset_cmd();
    test_rst_mid();
    test_mem_full();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qsm_readout_seq.md
Name: qsm_readout_seq

Overview:
- Sequencer for one QSPI master (QSM) channel.
- Turns the control-register pulses (reset, trig) and fields (last_reg_adr, max_dim_no, read_delay) into frame commands for the QSPI serial engine.
- Writes every returned DIM word into the channel's readout SRAM.
- Produces the status fields (busy, done, err_many, err_fb, dim_count) read back through the register map.
- One instance per channel, between the register bank/SRAM and the serial engine.

Parameters:
- MEM_AW, 7, readout SRAM word-address width (128 words).
- TIMEOUT, 65535, max clk_i cycles waiting for eng_ack_i before abort.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- ctrl_reset_i  in  1  one-cycle pulse: send Reset state to DIM line.
- ctrl_trig_i  in  1  one-cycle pulse: start DIM readout.
- last_reg_adr_i  in  4  index of last DIM register (registers 0..last_reg_adr_i).
- max_dim_no_i  in  4  max devices accepted per frame.
- read_delay_i  in  10  gap between register frames, in microseconds.
- tick_us_i  in  1  one-cycle strobe every 1 us.
- eng_rst_start_o  out  1  one-cycle pulse: engine issues line reset.
- eng_rd_start_o  out  1  one-cycle pulse: engine reads register eng_reg_o from all devices.
- eng_reg_o  out  4  register index for the current frame.
- eng_word_valid_i  in  1  eng_word_i valid (one per device, chain order).
- eng_word_i  in  16  device data word.
- eng_ack_i  in  1  one-cycle pulse: current engine command finished.
- eng_fb_err_i  in  1  qualified by eng_ack_i: feedback-line error in this frame.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  MEM_AW  SRAM word address.
- mem_data_o  out  16  SRAM write data.
- busy_o  out  1  sequencer not idle.
- done_o  out  1  sticky: readout finished.
- err_many_o  out  1  sticky: more words than max_dim_no_i in a frame.
- err_fb_o  out  1  sticky: feedback error or engine timeout.
- dim_count_o  out  4  devices detected in the register-0 frame.

Behaviour:
- Reset (rst_i=1): state IDLE; all outputs 0; counters 0. Takes effect from any state, discarding the frame in progress. The engine shares rst_i.
- States:
  - IDLE, RST_WAIT, RD_START, RD_WAIT, DELAY, FIN.
  - busy_o = (state != IDLE), registered.
- IDLE:
  - ctrl_reset_i=1 -> pulse eng_rst_start_o next cycle; clear done_o; go RST_WAIT.
  - Else ctrl_trig_i=1 -> clear done_o, err_many_o, err_fb_o and dim_count_o; reg_idx=0, wr_addr=0; go RD_START.
  - Reset wins over trig when both arrive in the same cycle.
  - Pulses outside IDLE are ignored (no queueing).
- RST_WAIT: on eng_ack_i go IDLE. done_o is not set.
- RD_START: eng_rd_start_o=1 for exactly one cycle with eng_reg_o=reg_idx; dev_cnt=0; go RD_WAIT. eng_reg_o holds until the next RD_START.
- RD_WAIT, per eng_word_valid_i:
  - If dev_cnt < max_dim_no_i: write the word, dev_cnt++.
  - Otherwise: word dropped, err_many_o=1.
  - Write path (registered, 1-cycle latency): mem_we_o=1, mem_addr_o=wr_addr, mem_data_o=eng_word_i; then wr_addr++.
  - When wr_addr = 2^MEM_AW-1 has been written, further words are dropped. No wrap, no error.
  - Storage is register-major, device-minor, packed.
- RD_WAIT, on eng_ack_i:
  - A word arriving in the same cycle as eng_ack_i is counted first.
  - If reg_idx=0: dim_count_o = dev_cnt, including that word.
  - If eng_fb_err_i: err_fb_o=1; go FIN (abort).
  - Else if reg_idx = last_reg_adr_i: go FIN.
  - Else: reg_idx++; load delay counter with read_delay_i; go DELAY.
- Timeout: in RD_WAIT and RST_WAIT a cycle counter runs. At TIMEOUT cycles without eng_ack_i: err_fb_o=1; go FIN from RD_WAIT, IDLE from RST_WAIT.
- DELAY:
  - Each tick_us_i decrements the counter.
  - At counter=0 go RD_START.
  - read_delay_i=0 -> RD_START on the next cycle.
  - The tick in the cycle of entry into DELAY is not counted.
- FIN: done_o=1; go IDLE. done_o stays 1 until the next trig or reset command.
- Control fields are sampled live. Changes mid-readout affect later comparisons only; software must not change them while busy_o=1.

Test Plan:
- Basic readout: last_reg_adr=1, max_dim_no=3, read_delay=0, engine returns 3 words/frame (0xA0..0xA2, 0xB0..0xB2).
  - mem addr 0..5 = A0,A1,A2,B0,B1,B2.
  - eng_reg_o 0 then 1.
  - dim_count_o=3, done_o=1, err bits 0.
  - busy_o drops the cycle after done_o rises.
- Too many devices: max_dim_no=2, engine returns 4 words -> only 2 writes/frame, err_many_o=1, dim_count_o=2, readout completes.
- Feedback error: eng_fb_err_i=1 with ack on reg 0 of last_reg_adr=3 -> no eng_rd_start_o for reg 1, err_fb_o=1, done_o=1.
- Delay: read_delay=5 -> exactly 5 tick_us_i between eng_ack_i and the next eng_rd_start_o. Trig while busy has no effect.
- Reset command: ctrl_reset_i and ctrl_trig_i together in IDLE -> eng_rst_start_o only. Engine never acks -> after TIMEOUT cycles, err_fb_o=1, busy_o=0, done_o=0.
- rst_i mid-RD_WAIT -> all outputs 0 next cycle. A subsequent trig restarts at mem address 0.
